aes_subshift_col_seq: RTL and testbench

//  Column-serial SubBytes+ShiftRows stage; sits directly upstream of aes_mixcolumn.

---
 rtl/aes_subshift_col_seq.sv | 171 +++++++++++++++++
 tb/tb_aes_subshift_col_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subshift_col_seq.sv
// Column-serial AES SubBytes+ShiftRows stage: captures a 128-bit state, then
// emits one substituted, row-shifted 32-bit column per cycle over valid/ready.

module aes_sbox #(
  parameter bit DEC_EN = 1'b1
) (
  input  logic [7:0] i_byte,
  input  logic       i_dec,
  output logic [7:0] o_byte
);

  logic [7:0] w_pre;
  logic [7:0] w_inv;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // Shared inverter; the affine step sits before it for InvS and after it for S.
  always_comb begin
    w_pre = i_byte;
    if (DEC_EN && i_dec) w_pre = inv_affine(i_byte);
    w_inv  = gf_inv(w_pre);
    o_byte = fwd_affine(w_inv);
    if (DEC_EN && i_dec) o_byte = w_inv;
  end

endmodule

module aes_subshift_col_seq #(
  parameter bit DEC_EN = 1'b1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_col,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         out_dec
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NROWS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             r_fsm;
  logic [1:0]         r_cnt;
  logic [STATE_W-1:0] r_state;
  logic               r_dec;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [COL_W-1:0]   r_out_col;
  logic [1:0]         r_out_idx;
  logic               r_out_last;
  logic               r_out_dec;

  logic               w_dec_sel;
  logic [COL_W-1:0]   w_col;
  logic               w_advance;

  assign w_dec_sel = DEC_EN & r_dec;
  assign w_advance = !r_out_valid || out_ready;

  // Row g of column r_cnt comes from column r_cnt+g (enc) or r_cnt-g (dec), mod 4.
  for (genvar g = 0; g < NROWS; g++) begin : g_row
    logic [1:0] w_src;
    assign w_src = w_dec_sel ? (r_cnt - 2'(g)) : (r_cnt + 2'(g));
    aes_sbox #(.DEC_EN(DEC_EN)) u_sbox (
      .i_byte (r_state[{w_src, 2'(g), 3'b000} +: BYTE_W]),
      .i_dec  (w_dec_sel),
      .o_byte (w_col[BYTE_W*g +: BYTE_W])
    );
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_fsm       <= ST_IDLE;
      r_cnt       <= '0;
      r_state     <= '0;
      r_dec       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_dec   <= 1'b0;
    end else begin
      unique case (r_fsm)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_state    <= in_state;
            r_dec      <= DEC_EN & in_dec;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_fsm      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_advance) begin
            r_out_col   <= w_col;
            r_out_idx   <= r_cnt;
            r_out_last  <= (r_cnt == 2'd3);
            r_out_dec   <= w_dec_sel;
            r_out_valid <= 1'b1;
            r_cnt       <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_fsm <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Column 3 is held here until it is taken.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_col   = r_out_col;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign out_dec   = r_out_dec;

endmodule

// File: tb/tb_aes_subshift_col_seq.sv
// Directed + random bench for aes_subshift_col_seq: hand-computed column tables,
// stall/back-to-back/reset sequences, and enc/dec round trips against a table model.

module tb_aes_subshift_col_seq;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_dec = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_col;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         out_dec;

  aes_subshift_col_seq #(.DEC_EN(1'b1)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_dec    (in_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_dec   (out_dec)
  );

  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic [31:0] col;
    logic [1:0]  idx;
    logic        last;
    logic        dec;
  } beat_t;

  typedef struct {
    logic [127:0] st;
    logic         dec;
    logic [31:0]  exp_col [4];
  } vec_t;

  beat_t       exp_q[$];
  logic [31:0] rx_col_q[$];
  int          rx_cyc_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          rdy_mode = 0;
  int          stall_left = 0;
  logic [7:0]  sbox [256];
  logic [7:0]  isbox [256];
  vec_t        tbl [6];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] model_col(input logic [127:0] st, input logic d, input int c);
    logic [31:0] col;
    logic [7:0]  b;
    int          src;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      src = d ? (c - r + 4) % 4 : (c + r) % 4;
      b   = st[8*(4*src + r) +: 8];
      col[8*r +: 8] = d ? isbox[b] : sbox[b];
    end
    return col;
  endfunction

  always @(posedge g_clk) cyc <= cyc + 1;

  // Downstream ready: 0 always ready, 1 random, 2 three-cycle stall on column 1.
  always @(posedge g_clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_idx == 2'd1 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  beat_t prev_beat;
  logic  prev_stall = 1'b0;

  // Output monitor: stall stability and in-order column scoreboard.
  always @(negedge g_clk) begin
    beat_t e;
    if (prev_stall && g_resetn)
      check("stall_hold", {out_valid, out_col, out_idx, out_last, out_dec}, {1'b1, prev_beat});
    prev_stall = g_resetn && out_valid && !out_ready;
    prev_beat  = '{col: out_col, idx: out_idx, last: out_last, dec: out_dec};
    if (g_resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_col: got %h idx %0d with no column expected", out_col, out_idx);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("col_idx%0d", e.idx), {out_col, out_idx, out_last, out_dec}, e);
      end
      rx_col_q.push_back(out_col);
      rx_cyc_q.push_back(cyc);
    end
  end

  task automatic push_exp(input logic d, input logic [31:0] ec [4]);
    for (int c = 0; c < 4; c++)
      exp_q.push_back('{col: ec[c], idx: 2'(c), last: (c == 3), dec: d});
  endtask

  task automatic send(input logic [127:0] st, input logic d, input logic [31:0] ec [4],
                      output int acc);
    int k;
    @(posedge g_clk); #1;
    in_valid = 1'b1;
    in_state = st;
    in_dec   = d;
    push_exp(d, ec);
    acc = -1;
    for (k = 0; k < 100; k++) begin
      @(negedge g_clk);
      if (in_ready) break;
    end
    if (k == 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      acc = cyc + 1;
    end
    @(posedge g_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge g_clk); #1;
    end
    if (k == 400) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d columns still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [127:0] rx_state(input int base);
    return {rx_col_q[base+3], rx_col_q[base+2], rx_col_q[base+1], rx_col_q[base]};
  endfunction

  initial begin
    logic [2047:0] sb_flat;
    logic [31:0]   ec [4];
    logic [31:0]   ec2 [4];
    logic [127:0]  st;
    logic [127:0]  y;
    logic          d;
    int            acc;
    int            acc2;
    int            base;
    int            n_low;
    int            k;

    sb_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox[i] = sb_flat[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);

    tbl[0] = '{128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b0,
               '{32'h305dbfd4, 32'hae52b4e0, 32'hf11141b8, 32'he598271e}};
    tbl[1] = '{128'he598271ef11141b8ae52b4e0305dbfd4, 1'b1,
               '{32'hbee33d19, 32'h2be2f4a0, 32'h2a8dc69a, 32'h0848f8e9}};
    tbl[2] = '{128'h0, 1'b0, '{32'h63636363, 32'h63636363, 32'h63636363, 32'h63636363}};
    tbl[3] = '{128'h0, 1'b1, '{32'h52525252, 32'h52525252, 32'h52525252, 32'h52525252}};
    tbl[4] = '{128'h03030303020202020101010100000000, 1'b0,
               '{32'h7b777c63, 32'h637b777c, 32'h7c637b77, 32'h777c637b}};
    tbl[5] = '{128'h03030303020202020101010100000000, 1'b1,
               '{32'h096ad552, 32'h6ad55209, 32'hd552096a, 32'h52096ad5}};

    // Reset values
    repeat (3) @(posedge g_clk);
    #1 g_resetn = 1'b1;
    @(negedge g_clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_dec", out_dec, 0);

    // Table vectors, always ready: latency and back-to-back column timing
    for (int i = 0; i < 6; i++) begin
      base = rx_col_q.size();
      send(tbl[i].st, tbl[i].dec, tbl[i].exp_col, acc);
      wait_drain();
      check($sformatf("tbl%0d_ncols", i), rx_col_q.size() - base, 4);
      if (rx_col_q.size() - base == 4) begin
        check($sformatf("tbl%0d_col0_lat", i), rx_cyc_q[base], acc + 1);
        check($sformatf("tbl%0d_col3_lat", i), rx_cyc_q[base+3], acc + 4);
      end
    end

    // Backpressure: three stalled cycles on column 1, then random ready
    rdy_mode   = 2;
    stall_left = 3;
    base = rx_col_q.size();
    send(tbl[0].st, tbl[0].dec, tbl[0].exp_col, acc);
    wait_drain();
    check("stall_used", stall_left, 0);
    if (rx_col_q.size() - base == 4) begin
      check("stall_col1_time", rx_cyc_q[base+1], acc + 5);
      check("stall_col2_time", rx_cyc_q[base+2], acc + 6);
    end
    rdy_mode = 1;
    send(tbl[0].st, tbl[0].dec, tbl[0].exp_col, acc);
    wait_drain();
    rdy_mode = 0;
    @(posedge g_clk); #1;

    // Back-to-back with in_valid held high across two blocks
    base = rx_col_q.size();
    in_valid = 1'b1;
    in_state = tbl[0].st;
    in_dec   = tbl[0].dec;
    push_exp(tbl[0].dec, tbl[0].exp_col);
    for (k = 0; k < 20; k++) begin
      @(negedge g_clk);
      if (in_ready) break;
    end
    check("b2b_first_accept", in_ready, 1);
    @(posedge g_clk); #1;
    in_state = tbl[1].st;
    in_dec   = tbl[1].dec;
    push_exp(tbl[1].dec, tbl[1].exp_col);
    n_low = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge g_clk);
      if (in_ready) break;
      n_low++;
    end
    check("b2b_ready_low_cycles", n_low, 5);
    check("b2b_first_block_cols", rx_col_q.size() - base, 4);
    if (rx_cyc_q.size() > 0) check("b2b_reaccept_edge", rx_cyc_q[rx_cyc_q.size()-1], cyc - 1);
    acc2 = cyc + 1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    wait_drain();
    check("b2b_total_cols", rx_col_q.size() - base, 8);
    if (rx_col_q.size() - base == 8) check("b2b_second_lat", rx_cyc_q[base+4], acc2 + 1);

    // Reset after column 1 transfers: partial block discarded
    base = rx_col_q.size();
    send(tbl[0].st, tbl[0].dec, tbl[0].exp_col, acc);
    for (k = 0; k < 20; k++) begin
      if (rx_col_q.size() - base >= 2) break;
      @(posedge g_clk); #1;
    end
    g_resetn = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_out_col", out_col, 0);
    check("rstmid_out_idx", out_idx, 0);
    exp_q.delete();
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    base = rx_col_q.size();
    send(tbl[0].st, tbl[0].dec, tbl[0].exp_col, acc);
    wait_drain();
    check("rstmid_resend_cols", rx_col_q.size() - base, 4);
    if (rx_col_q.size() - base == 4) check("rstmid_resend_lat", rx_cyc_q[base], acc + 1);

    // Random blocks with random ready, each followed by its inverse-direction round trip
    rdy_mode = 1;
    for (int n = 0; n < 500; n++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      d  = 1'($urandom_range(0, 1));
      for (int c = 0; c < 4; c++) ec[c] = model_col(st, d, c);
      base = rx_col_q.size();
      send(st, d, ec, acc);
      wait_drain();
      if (rx_col_q.size() - base != 4) begin
        check("rand_ncols", rx_col_q.size() - base, 4);
        break;
      end
      y = rx_state(base);
      for (int c = 0; c < 4; c++) ec2[c] = model_col(y, !d, c);
      base = rx_col_q.size();
      send(y, !d, ec2, acc);
      wait_drain();
      if (rx_col_q.size() - base != 4) begin
        check("rand_ncols", rx_col_q.size() - base, 4);
        break;
      end
      check("round_trip", rx_state(base), st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
